// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared widths, response-owner type and word-address helpers
package unified_mem_arbiter_pkg;

    localparam int BW_DEFAULT = 32;
    localparam int AW_DEFAULT = 10;
    // Byte offset of the word address inside a byte address (32-bit words).
    localparam int BYTE_OFF   = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MA   = 2'd2
    } resp_owner_e;

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// rtl/unified_mem_arbiter_starve_counter.sv - saturating fetch-denial counter that forces fetch priority
module unified_mem_arbiter_starve_counter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic             if_gnt,
    output logic             force_if,
    output logic [CNT_W-1:0] wait_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req || if_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(MAX_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == CNT_W'(MAX_WAIT));
    assign wait_cnt = cnt_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port RAM arbiter between fetch and memory-access stages
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int BW       = BW_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [BW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [BW-1:0] if_rdata,
    input  logic          ma_req,
    input  logic          ma_we,
    input  logic [BW-1:0] ma_addr,
    input  logic [BW-1:0] ma_wdata,
    output logic          ma_gnt,
    output logic          ma_rvalid,
    output logic [BW-1:0] ma_rdata,
    output logic          ma_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [BW-1:0] mem_wdata,
    input  logic [BW-1:0] mem_rdata,
    output logic          if_stall
);

    logic             force_if;
    logic [CNT_W-1:0] wait_cnt;
    logic             ma_wins;
    logic             if_wins;
    logic             ma_misaligned;

    resp_owner_e      resp_owner_q;
    resp_owner_e      resp_owner_d;
    logic             ma_err_q;
    logic             ma_err_d;
    logic [BW-1:0]    if_rdata_q;
    logic [BW-1:0]    if_rdata_d;
    logic [BW-1:0]    ma_rdata_q;
    logic [BW-1:0]    ma_rdata_d;

    // Upper address bits alias and fetch byte offset is ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[BW-1:AW+BYTE_OFF], if_addr[BYTE_OFF-1:0],
                                ma_addr[BW-1:AW+BYTE_OFF], wait_cnt};

    unified_mem_arbiter_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if),
        .wait_cnt (wait_cnt)
    );

    always_comb begin
        ma_wins       = ma_req && (!if_req || !force_if);
        if_wins       = if_req && !ma_wins;
        ma_misaligned = (ma_addr[BYTE_OFF-1:0] != '0);

        if_gnt   = if_wins;
        ma_gnt   = ma_wins;
        if_stall = if_req && !if_wins;

        // A misaligned data access still consumes the slot but never reaches the RAM.
        mem_en    = if_wins || (ma_wins && !ma_misaligned);
        mem_we    = ma_wins && ma_we && !ma_misaligned;
        mem_addr  = if_wins ? if_addr[BYTE_OFF +: AW] : ma_addr[BYTE_OFF +: AW];
        mem_wdata = ma_wdata;

        resp_owner_d = OWN_NONE;
        if (if_wins) begin
            resp_owner_d = OWN_IF;
        end else if (ma_wins && !ma_we && !ma_misaligned) begin
            resp_owner_d = OWN_MA;
        end
        ma_err_d = ma_wins && ma_misaligned;
    end

    always_comb begin
        if_rvalid  = (resp_owner_q == OWN_IF);
        ma_rvalid  = (resp_owner_q == OWN_MA);
        if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
        ma_rdata_d = ma_rvalid ? mem_rdata : ma_rdata_q;
        if_rdata   = if_rdata_d;
        ma_rdata   = ma_rdata_d;
        ma_err     = ma_err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_owner_q <= OWN_NONE;
            ma_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            ma_rdata_q   <= '0;
        end else begin
            resp_owner_q <= resp_owner_d;
            ma_err_q     <= ma_err_d;
            if_rdata_q   <= if_rdata_d;
            ma_rdata_q   <= ma_rdata_d;
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous RAM (instruction + data) between the Instruction Fetch stage (read-only) and the Memory Access stage (read/write).
- Data-side priority with an anti-starvation counter for fetch, byte-to-word address translation, misalignment trapping, and read-response routing.
- Sits between Instruction_Fetch / Memory_Access and the RAM macro.
- Drives a stall back to the pipeline controller while fetch is not being served.

Parameters:
- BW, 32, data/instruction/address bit width
- AW, 10, RAM word-address width (2^AW words)
- MAX_WAIT, 3, consecutive cycles IF may be denied before it gets forced priority (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  BW  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  BW  instruction word
- ma_req  in  1  data request; held with payload until ma_gnt
- ma_we  in  1  1 = write, 0 = read
- ma_addr  in  BW  data byte address
- ma_wdata  in  BW  write data
- ma_gnt  out  1  data request accepted this cycle (combinational)
- ma_rvalid  out  1  ma_rdata valid (reads only)
- ma_rdata  out  BW  load data
- ma_err  out  1  one-cycle pulse: misaligned data address, access dropped
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM word address
- mem_wdata  out  BW  RAM write data
- mem_rdata  in  BW  RAM read data, valid 1 cycle after mem_en & !mem_we
- if_stall  out  1  if_req & !if_gnt (combinational)

Behaviour:
- Reset (rst=0, async): wait_cnt=0, resp_owner=NONE, if_rvalid=0, ma_rvalid=0, ma_err=0. Combinational outputs follow inputs with those state values: with no requests, mem_en=0, gnt=0. Reset mid-read drops the pending response; no rvalid after release.
- Handshake: a requester keeps req and payload stable until it samples gnt=1. gnt is high for exactly the cycle the access is issued. A requester may present a new request in the cycle after gnt.
- Arbitration, per cycle:
  - Only one requester active: it wins.
  - Both active: MA wins unless wait_cnt == MAX_WAIT, in which case IF wins.
  - Winner's req is converted that same cycle: mem_en=1, mem_addr=addr[AW+1:2], mem_we=ma_we (0 for IF), mem_wdata=ma_wdata.
  - Upper bits addr[BW-1:AW+2] are ignored (alias/wrap).
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
- Misalignment:
  - ma_addr[1:0] != 0 and MA wins: ma_gnt=1, mem_en=0, ma_err=1 registered (next cycle), no rvalid.
  - The slot is consumed; IF is not granted that cycle.
  - if_addr[1:0] is ignored (fetch is always word aligned).
- Response routing:
  - resp_owner is registered on each granted read (IF, MA, or NONE for write/err/idle).
  - Next cycle: owner's rvalid=1 and rdata=mem_rdata. The other rvalid=0, and its rdata holds its last value (registered capture).
  - Read latency is exactly 1 cycle after gnt. Back-to-back reads give throughput of 1 access per cycle.
- Write then read of the same word in consecutive cycles returns the new data (RAM write-first is not required; the write is complete before the next read is issued).
- rvalid has no backpressure; requesters must accept data in that cycle.

Decomposition:
- Shared package (cpu_pkg): BW, AW defaults; resp_owner enum {OWN_NONE, OWN_IF, OWN_MA}; word-address slice helper constant (byte offset = 2).
- One sub-module is natural: starve_counter (saturating counter with clear, MAX_WAIT param, outputs force_if). The rest stays in the top.

Test Plan:
- Reset then idle, rst=1, no req -> mem_en=0, both gnt=0, both rvalid=0, if_stall=0.
- IF only, if_addr=0x0000_0010, RAM[4]=0x0000_0013 -> if_gnt same cycle, mem_addr=4, next cycle if_rvalid=1, if_rdata=0x0000_0013.
- Contention with MAX_WAIT=3: ma_req held high with writes to 0x40,0x44,0x48,0x4C, if_req high.
  - -> MA granted in cycles 0-2; IF granted in cycle 3 (if_stall=1 in cycles 0-2); MA granted in cycle 4.
  - -> wait_cnt returns to 0.
- MA store then load: sw 0xDEADBEEF @0x80, then lw @0x80 next cycle -> mem_we=1 then 0, ma_rvalid=1 one cycle after the load grant, ma_rdata=0xDEADBEEF, if_rvalid=0.
- Misaligned: ma_req, ma_addr=0x0000_0082 -> ma_gnt=1, mem_en=0, ma_err=1 next cycle, ma_rvalid stays 0.
- Reset mid-read: IF read granted, rst=0 in the following cycle before the clock edge -> if_rvalid=0, resp_owner=NONE, no rvalid after rst returns high.
